// File: rtl/l2_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_pkg
// Purpose  : Shared types and helpers for the N-way L2 cache controller:
//            controller state encoding, default geometry and a priority
//            encoder that maps a bit vector to the index of its lowest set bit.
// Revision : 1.0 - initial release
// ============================================================================
package l2_cache_pkg;

    localparam int c_nways_default = 4;
    localparam int c_way_w_default = $clog2(c_nways_default);

    // Widest way vector the index helper accepts, and its index width.
    localparam int c_max_ways = 32;
    localparam int c_idx_w    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EVICT  = 2'd2,
        ST_FILL   = 2'd3
    } state_t;

    // One-hot to index. With more than one bit set the lowest index wins,
    // which is what both hit-way selection and invalid-way-first need.
    function automatic logic [c_idx_w-1:0] onehot_to_idx(input logic [c_max_ways-1:0] vec);
        onehot_to_idx = '0;
        for (int i = c_max_ways - 1; i >= 0; i--) begin
            if (vec[i]) begin
                onehot_to_idx = c_idx_w'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cache_ctrl_nway_plru.sv
`default_nettype none
// ============================================================================
// Module   : plru_tree
// Purpose  : Combinational tree pseudo-LRU helper for one cache set.
//            Node i of the heap-ordered tree has children 2i+1 and 2i+2;
//            a node bit of 0 points to the lower half of ways, 1 to the upper.
// Ports    : bits_in    - current tree of the set
//            access_way - way being touched
//            victim_way - way the tree currently points at
//            bits_out   - tree updated so every node on the path of
//                         access_way points away from it
// Revision : 1.0 - initial release
// ============================================================================
module plru_tree #(
    parameter int NWAYS = 4,
    parameter int WAY_W = $clog2(NWAYS)
) (
    input  logic [NWAYS-2:0] bits_in,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim_way,
    output logic [NWAYS-2:0] bits_out
);

    // Walk from the root; the partial way number built so far is also the
    // offset of the next node within its level.
    always_comb begin
        victim_way = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_way = (victim_way << 1)
                       | WAY_W'(bits_in[WAY_W'((1 << l) - 1) + victim_way]);
        end
    end

    // One node per generated instance; a node is on the access path when the
    // upper l bits of access_way equal its position within level l.
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        for (genvar p = 0; p < (1 << l); p++) begin : g_node
            localparam int c_node = (1 << l) - 1 + p;
            logic w_on_path;
            if (l == 0) begin : g_root
                assign w_on_path = 1'b1;
            end else begin : g_inner
                assign w_on_path = ((access_way >> (WAY_W - l)) == WAY_W'(p));
            end
            assign bits_out[c_node] = w_on_path ? ~access_way[WAY_W-1-l] : bits_in[c_node];
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_ctrl_nway
// Purpose  : Control FSM for an NWAYS-way write-back, write-allocate L2 cache
//            with tree PLRU replacement, invalid-way-first victim choice,
//            saturating hit/miss counters and a sticky multi-hit error flag.
// Ports    : clk, rst (sync, active-high)
//            cpu_read/cpu_write/cpu_resp        - L1 miss path handshake
//            hit_vec/valid_vec/dirty_vec        - state of the indexed set
//            plru_bits_in/plru_bits_out/ld_plru - PLRU tree read/update
//            pmem_read/pmem_write/pmem_resp     - memory handshake
//            wb_addr_sel, access_way            - address / data mux selects
//            data_cpu_we, data_fill_we, ld_tag, ld_valid, ld_dirty,
//            valid_in, dirty_in                 - array writes
//            hit_cnt, miss_cnt, multi_hit_err, busy - status
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache_ctrl_nway
    import l2_cache_pkg::*;
#(
    parameter int NWAYS  = c_nways_default,
    parameter int WAY_W  = $clog2(NWAYS),
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [NWAYS-1:0]  hit_vec,
    input  logic [NWAYS-1:0]  valid_vec,
    input  logic [NWAYS-1:0]  dirty_vec,
    input  logic [NWAYS-2:0]  plru_bits_in,
    input  logic              pmem_resp,
    output logic              cpu_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic              wb_addr_sel,
    output logic [WAY_W-1:0]  access_way,
    output logic [NWAYS-1:0]  data_cpu_we,
    output logic [NWAYS-1:0]  data_fill_we,
    output logic [NWAYS-1:0]  ld_tag,
    output logic [NWAYS-1:0]  ld_valid,
    output logic [NWAYS-1:0]  ld_dirty,
    output logic              valid_in,
    output logic              dirty_in,
    output logic              ld_plru,
    output logic [NWAYS-2:0]  plru_bits_out,
    output logic [PERF_W-1:0] hit_cnt,
    output logic [PERF_W-1:0] miss_cnt,
    output logic              multi_hit_err,
    output logic              busy
);

    state_t            r_state, w_state_nxt;
    logic [WAY_W-1:0]  r_victim;
    logic              r_refill;
    logic              r_multi_hit;
    logic [PERF_W-1:0] r_hit_cnt, r_miss_cnt;

    logic              w_req, w_hit, w_multi, w_any_invalid;
    logic [WAY_W-1:0]  w_hit_way, w_plru_victim, w_victim;
    logic [NWAYS-1:0]  w_hit_oh, w_victim_oh;
    logic [NWAYS-2:0]  w_plru_upd;

    assign w_req         = cpu_read | cpu_write;
    assign w_hit         = |hit_vec;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi       = |(hit_vec & (hit_vec - NWAYS'(1)));
    assign w_any_invalid = ~&valid_vec;
    assign w_hit_way     = WAY_W'(onehot_to_idx(c_max_ways'(hit_vec)));
    assign w_victim      = w_any_invalid ? WAY_W'(onehot_to_idx(c_max_ways'(~valid_vec)))
                                         : w_plru_victim;
    assign w_hit_oh      = NWAYS'(1) << w_hit_way;
    assign w_victim_oh   = NWAYS'(1) << r_victim;

    plru_tree #(
        .NWAYS (NWAYS),
        .WAY_W (WAY_W)
    ) u_plru (
        .bits_in    (plru_bits_in),
        .access_way (w_hit_way),
        .victim_way (w_plru_victim),
        .bits_out   (w_plru_upd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_victim    <= '0;
            r_refill    <= 1'b0;
            r_multi_hit <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_LOOKUP) begin
                // LOOKUP always exits after one cycle, ending any refill.
                r_refill <= 1'b0;
                if (w_multi) begin
                    r_multi_hit <= 1'b1;
                end
                if (w_req && w_hit) begin
                    // The re-lookup after a fill is not a genuine hit.
                    if (!r_refill && (r_hit_cnt != '1)) begin
                        r_hit_cnt <= r_hit_cnt + PERF_W'(1);
                    end
                end else if (w_req) begin
                    r_victim <= w_victim;
                    if (r_miss_cnt != '1) begin
                        r_miss_cnt <= r_miss_cnt + PERF_W'(1);
                    end
                end
            end
            if ((r_state == ST_FILL) && pmem_resp) begin
                r_refill <= 1'b1;
            end
        end
    end

    // Outputs are forced low while rst is high so an abandoned EVICT/FILL
    // cannot issue an array load in the reset cycle.
    always_comb begin
        w_state_nxt   = r_state;
        cpu_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        wb_addr_sel   = 1'b0;
        access_way    = '0;
        data_cpu_we   = '0;
        data_fill_we  = '0;
        ld_tag        = '0;
        ld_valid      = '0;
        ld_dirty      = '0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        ld_plru       = 1'b0;
        plru_bits_out = '0;
        busy          = 1'b0;
        if (!rst) begin
            busy       = (r_state != ST_IDLE);
            access_way = r_victim;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_state_nxt = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    access_way = w_hit_way;
                    if (!w_req) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_hit) begin
                        cpu_resp      = 1'b1;
                        ld_plru       = 1'b1;
                        plru_bits_out = w_plru_upd;
                        if (cpu_write) begin
                            data_cpu_we = w_hit_oh;
                            ld_dirty    = w_hit_oh;
                            dirty_in    = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end else if (valid_vec[w_victim] && dirty_vec[w_victim]) begin
                        w_state_nxt = ST_EVICT;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_EVICT: begin
                    pmem_write  = 1'b1;
                    wb_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        ld_dirty    = w_victim_oh;
                        w_state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_fill_we = w_victim_oh;
                        ld_tag       = w_victim_oh;
                        ld_valid     = w_victim_oh;
                        ld_dirty     = w_victim_oh;
                        valid_in     = 1'b1;
                        w_state_nxt  = ST_LOOKUP;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;
    assign multi_hit_err = r_multi_hit;

endmodule
`default_nettype wire

// File: doc/l2_cache_ctrl_nway.md
# l2_cache_ctrl_nway

Control FSM for a parametrised NWAYS-way, write-back, write-allocate L2 cache. It sits between the L1 miss path (CPU side) and physical memory, and drives the tag, valid, dirty, data and PLRU arrays of one indexed set per request. Over the 2-way design it adds three things: tree pseudo-LRU replacement, invalid-way-first victim choice, and hit/miss performance counters with a sticky multi-hit error flag.

## Interface
Parameters:
- NWAYS, 4, number of ways; power of two, at least 2.
- WAY_W, $clog2(NWAYS), way index width.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_read, cpu_write  in  1 each  request; level, held until cpu_resp; never both high.
- hit_vec  in  NWAYS  valid-qualified tag match per way.
- valid_vec, dirty_vec  in  NWAYS  state of the indexed set.
- plru_bits_in  in  NWAYS-1  PLRU tree of the indexed set; bit i is heap node i (root 0, children 2i+1 and 2i+2).
- pmem_resp  in  1  memory completion.
- cpu_resp  out  1  request complete.
- pmem_read, pmem_write  out  1 each  memory request; held until pmem_resp.
- wb_addr_sel  out  1  pmem address taken from the victim tag (high only in EVICT).
- access_way  out  WAY_W  way for the data mux: hit way in LOOKUP, latched victim otherwise.
- data_cpu_we, data_fill_we  out  NWAYS  one-hot data array writes.
- ld_tag, ld_valid, ld_dirty  out  NWAYS  one-hot array loads.
- valid_in, dirty_in  out  1 each  values written on load.
- ld_plru  out  1; plru_bits_out  out  NWAYS-1  updated tree.
- hit_cnt, miss_cnt  out  PERF_W  saturating counters.
- multi_hit_err  out  1  sticky error flag.
- busy  out  1  state is not IDLE.

## Operation
- States are IDLE, LOOKUP, EVICT, FILL.
- IDLE: go to LOOKUP when cpu_read or cpu_write is high.
- LOOKUP, no request: go to IDLE with no response. This covers a request dropped mid-miss.
- LOOKUP, hit (hit_vec != 0): hit way is the lowest set bit.
  - Assert cpu_resp, ld_plru, and plru_bits_out equal to plru_bits_in with the path bits pointing away from the hit way.
  - On a write, also assert data_cpu_we[hit], ld_dirty[hit] and dirty_in=1.
  - Go to IDLE.
- LOOKUP, miss: latch the victim into victim_q.
  - Victim is the lowest-index invalid way if any way is invalid; otherwise the PLRU victim.
  - PLRU victim: start at the root; bit 0 means go left (lower ways), bit 1 means go right.
  - Go to EVICT if the victim is valid and dirty; otherwise go to FILL.
- EVICT: pmem_write=1 and wb_addr_sel=1. On pmem_resp, assert ld_dirty[victim_q] with dirty_in=0, then go to FILL.
- FILL: pmem_read=1. On pmem_resp, assert data_fill_we, ld_tag and ld_valid for victim_q, with valid_in=1, ld_dirty with dirty_in=0. Then go to LOOKUP, which is the re-lookup that hits.
- Counters:
  - miss_cnt increments on a miss in LOOKUP.
  - hit_cnt increments on a hit in LOOKUP only when refill_q=0.
  - refill_q is set on leaving FILL and cleared when LOOKUP exits.
  - Both counters saturate at all-ones.
- multi_hit_err is set when more than one bit of hit_vec is high in LOOKUP. It stays set until rst.

## Timing
- Hit: cpu_resp is combinational in the single LOOKUP cycle, so latency is 2 cycles from request to response.
- Clean miss: IDLE, LOOKUP, FILL for N cycles, then LOOKUP with cpu_resp.
- Dirty miss: adds EVICT before FILL.
- All array loads are single-cycle pulses in the cycle they are listed in.
- pmem_resp is ignored outside EVICT and FILL.
- pmem_resp in the first cycle of EVICT or FILL is legal and completes that state immediately.
- Reset values:
  - State is IDLE, with victim_q=0, refill_q=0, counters=0 and multi_hit_err=0.
  - Every output is 0, including access_way=0 and plru_bits_out=0.
- rst mid-EVICT or mid-FILL: pmem_read and pmem_write drop in the next cycle, and no array load is issued. Abandoning the memory transaction is the memory side's concern.

## Structure
- Package l2_cache_pkg holds the state enum, the NWAYS and WAY_W defaults, and a one-hot-to-index function.
- Sub-module plru_tree is combinational and parametrised on NWAYS.
  - Inputs: bits_in, access_way. Outputs: victim_way, bits_out.
  - It is generated per tree level.
- Target size is around 250 lines of RTL.

## Test plan
All scenarios use NWAYS=4 unless noted.
- Read hit on way 2 (hit_vec=0100, plru_bits_in=000) -> cpu_resp in LOOKUP, ld_plru=1, plru_bits_out=100, hit_cnt=1, no pmem activity.
- Read miss, valid_vec=1011 -> victim 2, no EVICT; pmem_read held 5 cycles until pmem_resp; ld_tag, ld_valid and data_fill_we = 0100; re-lookup hit gives cpu_resp; miss_cnt=1, hit_cnt=0.
- Write miss, valid=dirty=1111, plru_bits_in=011 -> victim 2; EVICT with pmem_write and wb_addr_sel; clean ld_dirty=0100; FILL; re-lookup data_cpu_we=0100, ld_dirty=0100, dirty_in=1.
- hit_vec=0110 -> way 1 used, multi_hit_err=1 and remains set over 10 further clean requests.
- rst asserted on the third FILL cycle -> next cycle all outputs 0, busy=0, counters 0; a following read proceeds normally.
- PERF_W=4, 20 read hits -> hit_cnt=1111, no wrap.
